p4_adder_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational P4 adder. Splits an NBIT add/subtract into STAGES carry-chained segments, one segment per register stage. Carries a valid/ready handshake on both sides, with full back-pressure. It sits on the datapath between an operand source and a result consumer, and is driven and monitored by the same clocking-block style verification environment.

---
 rtl/p4_adder_pipe_if.sv | 26 ++
 rtl/p4_adder_pipe.sv | 104 ++++++++++
 tb/tb_p4_adder_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/p4_adder_pipe_if.sv
// rtl/p4_adder_pipe_if.sv - operand request / result handshake bundle for p4_adder_pipe
interface p4_adder_pipe_if #(
    parameter int NBIT = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            cin;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] s;
    logic            cout;
    logic            ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/p4_adder_pipe.sv
// rtl/p4_adder_pipe.sv - pipelined add/subtract, one carry-chained segment per stage
module p4_adder_pipe #(
    parameter int NBIT   = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    p4_adder_pipe_if.slave  bus
);
    localparam int SEG = NBIT / ((STAGES < 1) ? 1 : STAGES);

    if (STAGES < 1 || (NBIT % STAGES) != 0) begin : g_param_check
        $error("p4_adder_pipe: NBIT must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [NBIT-1:0]   op_a_q [STAGES];
    logic [NBIT-1:0]   op_b_q [STAGES];
    logic [NBIT-1:0]   res_q  [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] en;
    logic              src_v  [STAGES];
    logic              src_c  [STAGES];
    logic [NBIT-1:0]   src_a  [STAGES];
    logic [NBIT-1:0]   src_b  [STAGES];
    logic [NBIT-1:0]   src_r  [STAGES];
    logic [NBIT-1:0]   nxt_r  [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic              nxt_ovf;

    always_comb begin
        logic          acc;
        logic [SEG:0]  sum;
        // a stage may load if it is empty or anything between it and the output drains
        acc = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc || !v_q[k];
            en[k] = acc;
        end

        // subtract is a + ~b + ~cin, so borrow-in inverts into the carry chain
        src_v[0] = bus.in_valid;
        src_a[0] = bus.a;
        src_b[0] = bus.sub ? ~bus.b : bus.b;
        src_r[0] = '0;
        src_c[0] = bus.sub ^ bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = op_a_q[k-1];
            src_b[k] = op_b_q[k-1];
            src_r[k] = res_q[k-1];
            src_c[k] = c_q[k-1];
        end

        sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                + (SEG+1)'(src_c[k]);
            nxt_r[k]                = src_r[k];
            nxt_r[k][k*SEG +: SEG]  = sum[SEG-1:0];
            nxt_c[k]                = sum[SEG];
        end

        // a ^ b' ^ s at the MSB recovers the carry into it
        nxt_ovf = src_a[STAGES-1][NBIT-1] ^ src_b[STAGES-1][NBIT-1]
                ^ nxt_r[STAGES-1][NBIT-1] ^ nxt_c[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                op_a_q[k] <= '0;
                op_b_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        op_a_q[k] <= src_a[k];
                        op_b_q[k] <= src_b[k];
                        res_q[k]  <= nxt_r[k];
                        c_q[k]    <= nxt_c[k];
                    end
                end
            end
            if (en[STAGES-1] && src_v[STAGES-1]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end

    assign bus.in_ready  = en[0] && !rst;
    assign bus.out_valid = v_q[STAGES-1] && !rst;
    assign bus.s         = rst ? '0 : res_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1] && !rst;
    assign bus.ovf       = ovf_q && !rst;
endmodule

// File: tb/tb_p4_adder_pipe.sv
// tb/tb_p4_adder_pipe.sv - randomized and directed bench for p4_adder_pipe against an arithmetic model
module tb_p4_adder_pipe;
    localparam int NBIT   = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p4_adder_pipe_if #(.NBIT(NBIT)) bus ();
    p4_adder_pipe #(.NBIT(NBIT), .STAGES(STAGES)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic [33:0] model_q [$];
    logic [31:0] dlv_s [$];
    int unsigned dlv_t [$];
    logic        hold;
    logic [33:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // {s, cout, ovf} from plain wide arithmetic; sub reports cout = no borrow
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic sb);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, o;
        if (!sb) begin
            w = {1'b0, x} + {1'b0, y} + {32'b0, ci};
            r = w[31:0];
            c = w[32];
            o = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            w = {1'b0, x} - {1'b0, y} - {32'b0, ci};
            r = w[31:0];
            c = !w[32];
            o = (x[31] != y[31]) && (r[31] != x[31]);
        end
        return {r, c, o};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            hold = 1'b0;
        end else begin
            if (hold)
                check("hold_stable", 64'({bus.out_valid, bus.s, bus.cout, bus.ovf}),
                      64'({1'b1, held}));
            if (bus.out_valid && bus.out_ready) begin
                if (model_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got s=%0h expected no result", bus.s);
                end else begin
                    check("stream", 64'({bus.s, bus.cout, bus.ovf}), 64'(model_q.pop_front()));
                end
                dlv_s.push_back(bus.s);
                dlv_t.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready)
                model_q.push_back(ref_op(bus.a, bus.b, bus.cin, bus.sub));
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.s, bus.cout, bus.ovf};
        end
    end

    // call at posedge+1; checks latency in edges counting the accepting edge
    task automatic op_check(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tc, input logic ts,
                            input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.sub = ts;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(STAGES));
        check({nm, "_s"}, 64'(bus.s), 64'(es));
        check({nm, "_cout"}, 64'(bus.cout), 64'(ec));
        check({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        int g = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (model_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check({nm, "_drained"}, 64'(model_q.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_n, guard, gaps;
        logic was_acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'({bus.out_valid, bus.in_ready, bus.s, bus.cout, bus.ovf}), 64'(0));

        check("model_wrap", 64'(ref_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({32'h0, 1'b1, 1'b0}));
        check("model_sub",  64'(ref_op(32'd5, 32'd7, 1'b0, 1'b1)), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
        check("model_sovf", 64'(ref_op(32'h8000_0000, 32'h1, 1'b0, 1'b1)), 64'({32'h7FFF_FFFF, 1'b1, 1'b1}));

        @(posedge clk); #1;
        rst = 1'b0;

        op_check("wrap",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op_check("ripple", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        op_check("povf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op_check("sub57",  32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op_check("sub75b", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        op_check("subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // back-pressure: fill, hold, release
        dlv_s.delete(); dlv_t.delete();
        bus.out_ready = 1'b0;
        bus.cin = 1'b0; bus.sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a = 32'(i); bus.b = 32'(i); bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp_accept", 64'(bus.in_ready), 64'(1));
            @(posedge clk); #1;
        end
        bus.a = 32'd4; bus.b = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full", 64'({bus.in_ready, bus.out_valid, bus.s}), 64'({1'b0, 1'b1, 32'h0}));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        check("bp_accept5", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        wait_drain("bp");
        check("bp_count", 64'(dlv_s.size()), 64'(6));
        for (int i = 0; i < dlv_s.size(); i++) begin
            check("bp_order", 64'(dlv_s[i]), 64'(2 * i));
            if (i > 0) check("bp_rate", 64'(dlv_t[i] - dlv_t[i-1]), 64'(1));
        end

        // random stream with random valid/ready
        dlv_s.delete(); dlv_t.delete();
        acc_n = 0; guard = 0; was_acc = 1'b0;
        bus.in_valid = 1'b0;
        while (acc_n < 10000 && guard < 60000) begin
            if (!bus.in_valid || was_acc) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.a = rnd_op(); bus.b = rnd_op();
                bus.cin = 1'($urandom_range(1)); bus.sub = 1'($urandom_range(1));
            end
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            was_acc = bus.in_valid && bus.in_ready;
            if (was_acc) acc_n++;
            @(posedge clk); #1;
            guard++;
        end
        check("rand_accepts", 64'(acc_n), 64'(10000));
        wait_drain("rand");
        check("rand_delivered", 64'(dlv_s.size()), 64'(acc_n));

        // back-to-back throughput
        dlv_s.delete(); dlv_t.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.a = $urandom(); bus.b = $urandom();
            bus.cin = 1'($urandom_range(1)); bus.sub = 1'($urandom_range(1));
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("tp_ready", 64'(bus.in_ready), 64'(1));
            @(posedge clk); #1;
        end
        wait_drain("tp");
        gaps = 0;
        for (int i = 1; i < dlv_t.size(); i++)
            if (dlv_t[i] - dlv_t[i-1] != 1) gaps++;
        check("tp_count", 64'(dlv_s.size()), 64'(40));
        check("tp_gaps", 64'(gaps), 64'(0));

        // reset with three requests in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a = 32'(100 + i); bus.b = 32'd1; bus.cin = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", 64'({bus.out_valid, bus.in_ready, bus.s, bus.cout, bus.ovf}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        dlv_s.delete(); dlv_t.delete();
        op_check("post_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_count", 64'(dlv_s.size()), 64'(1));
        if (dlv_s.size() > 0) check("post_rst_value", 64'(dlv_s[0]), 64'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
